// File: rtl/input_conditioner.sv
// input_conditioner: per-channel counter debounce, mode-selectable edge strobe and retriggerable pulse stretcher.
// Define INPUT_COND_SYNC_EN to place a 2-flop synchroniser ahead of the sample register (adds 2 cycles).
module input_conditioner #(
    parameter int NCH         = 4,
    parameter int DB_LEN      = 4,
    parameter int STRETCH_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   in,
    input  logic [2*NCH-1:0] edge_mode,
    output logic [NCH-1:0]   level,
    output logic [NCH-1:0]   pulse,
    output logic [NCH-1:0]   stretched,
    output logic             any_pulse
);
    localparam int CW = (DB_LEN > 1) ? $clog2(DB_LEN) : 1;
    localparam int SW = (STRETCH_LEN > 1) ? $clog2(STRETCH_LEN) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(DB_LEN - 1);
    localparam logic [SW-1:0] S_LOAD = SW'(STRETCH_LEN - 1);

    logic [NCH-1:0] s_src;

`ifdef INPUT_COND_SYNC_EN
    logic [NCH-1:0] sync1;
    logic [NCH-1:0] sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
        end
    end

    assign s_src = sync2;
`else
    assign s_src = in;
`endif

    logic [NCH-1:0] s;
    logic [CW-1:0]  cnt  [NCH];
    logic [SW-1:0]  scnt [NCH];
    logic [NCH-1:0] flip;
    logic [NCH-1:0] pulse_nxt;

    // Mode is only looked at on the flip edge, so mode changes never disturb an in-flight pulse or stretch.
    always_comb begin
        flip      = '0;
        pulse_nxt = '0;
        for (int i = 0; i < NCH; i++) begin
            flip[i] = (s[i] != level[i]) && (cnt[i] == C_LAST);
            case (edge_mode[2*i +: 2])
                2'b00:   pulse_nxt[i] = flip[i] & ~level[i];
                2'b01:   pulse_nxt[i] = flip[i] & level[i];
                2'b10:   pulse_nxt[i] = flip[i];
                default: pulse_nxt[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s         <= '0;
            level     <= '0;
            pulse     <= '0;
            stretched <= '0;
            any_pulse <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i]  <= '0;
                scnt[i] <= '0;
            end
        end else begin
            s         <= s_src;
            pulse     <= pulse_nxt;
            any_pulse <= |pulse_nxt;
            for (int i = 0; i < NCH; i++) begin
                if (s[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (flip[i]) begin
                    level[i] <= ~level[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end

                // A fresh pulse reloads the counter, giving a gap-free extension on retrigger.
                if (pulse_nxt[i]) begin
                    scnt[i]      <= S_LOAD;
                    stretched[i] <= 1'b1;
                end else if (scnt[i] != '0) begin
                    scnt[i]      <= scnt[i] - 1'b1;
                    stretched[i] <= 1'b1;
                end else begin
                    stretched[i] <= 1'b0;
                end
            end
        end
    end
endmodule
